// File: rtl/hazard_tracker.sv
// hazard_tracker: decodes write-back info in D and carries it down E/M/W
// for the stall unit and forwarding muxes. Tnew counts down one per stage.
module hazard_tracker #(
  parameter int unsigned RA_REG = 31,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic             stop,
  output logic [4:0]       A3_E,
  output logic [4:0]       A3_M,
  output logic [4:0]       A3_W,
  output logic             RegWr_E,
  output logic             RegWr_M,
  output logic             RegWr_W,
  output logic [1:0]       Tnew_E,
  output logic [1:0]       Tnew_M,
  output logic [1:0]       Tnew_W,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef struct packed {
    logic [4:0] a3;
    logic       rw;
    logic [1:0] tn;
  } wb_t;

  wb_t e_q, m_q, w_q;
  wb_t dec_c;
  wb_t raw_c;
  wb_t m_nxt_c, w_nxt_c;

  logic [5:0] op_c;
  logic [5:0] fn_c;
  logic [4:0] rt_c;
  logic [4:0] rd_c;

  assign op_c = instr_D[31:26];
  assign fn_c = instr_D[5:0];
  assign rt_c = instr_D[20:16];
  assign rd_c = instr_D[15:11];

  // Decode destination, write enable and Tnew; $0 destinations are never hazards
  always_comb begin
    raw_c = '0;
    unique case (op_c)
      OP_RTYPE: begin
        if (fn_c == FN_ADDU || fn_c == FN_SUBU) begin
          raw_c.a3 = rd_c;
          raw_c.rw = 1'b1;
          raw_c.tn = 2'd1;
        end
      end
      OP_ORI, OP_LUI: begin
        raw_c.a3 = rt_c;
        raw_c.rw = 1'b1;
        raw_c.tn = 2'd1;
      end
      OP_LW: begin
        raw_c.a3 = rt_c;
        raw_c.rw = 1'b1;
        raw_c.tn = 2'd2;
      end
      OP_JAL: begin
        raw_c.a3 = 5'(RA_REG);
        raw_c.rw = 1'b1;
        raw_c.tn = 2'd0;
      end
      default: raw_c = '0;
    endcase
    dec_c = raw_c;
    if (raw_c.a3 == 5'd0) begin
      dec_c.rw = 1'b0;
      dec_c.tn = 2'd0;
    end
  end

  // Next M/W contents with saturating Tnew decrement
  always_comb begin
    m_nxt_c    = e_q;
    m_nxt_c.tn = (e_q.tn == 2'd0) ? 2'd0 : e_q.tn - 2'd1;
    w_nxt_c    = m_q;
    w_nxt_c.tn = (m_q.tn == 2'd0) ? 2'd0 : m_q.tn - 2'd1;
  end

  // Pipeline registers: E takes a bubble on stop, M/W always advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= stop ? wb_t'('0) : dec_c;
      m_q <= m_nxt_c;
      w_q <= w_nxt_c;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stop && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign A3_E    = e_q.a3;
  assign A3_M    = m_q.a3;
  assign A3_W    = w_q.a3;
  assign RegWr_E = e_q.rw;
  assign RegWr_M = m_q.rw;
  assign RegWr_W = w_q.rw;
  assign Tnew_E  = e_q.tn;
  assign Tnew_M  = m_q.tn;
  assign Tnew_W  = w_q.tn;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker (CNT_W = 4 build).
module tb_hazard_tracker;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [31:0]      instr_D;
  logic             stop;
  logic [4:0]       A3_E, A3_M, A3_W;
  logic             RegWr_E, RegWr_M, RegWr_W;
  logic [1:0]       Tnew_E, Tnew_M, Tnew_W;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_tracker #(.RA_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .stop(stop),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .RegWr_E(RegWr_E), .RegWr_M(RegWr_M), .RegWr_W(RegWr_W),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .Tnew_W(Tnew_W),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b0;
    stop    = 1'b0;
    instr_D = 32'h0;
    #12;
    chk("rst_a3e", 32'(A3_E), 32'd0);
    chk("rst_rwe", 32'(RegWr_E), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // lw $3 flows through E, M, W
    instr_D = 32'h8C030000;
    step();
    chk("lw_a3e", 32'(A3_E), 32'd3);
    chk("lw_rwe", 32'(RegWr_E), 32'd1);
    chk("lw_tne", 32'(Tnew_E), 32'd2);
    instr_D = 32'h0;
    step();
    chk("lw_a3m", 32'(A3_M), 32'd3);
    chk("lw_tnm", 32'(Tnew_M), 32'd1);
    chk("nop_a3e", 32'(A3_E), 32'd0);
    step();
    chk("lw_a3w", 32'(A3_W), 32'd3);
    chk("lw_tnw", 32'(Tnew_W), 32'd0);
    chk("lw_rww", 32'(RegWr_W), 32'd1);

    // stall: bubble into E while M advances
    instr_D = 32'h8C030000;
    step();
    stop = 1'b1;
    step();
    chk("stl_a3e", 32'(A3_E), 32'd0);
    chk("stl_rwe", 32'(RegWr_E), 32'd0);
    chk("stl_tne", 32'(Tnew_E), 32'd0);
    chk("stl_a3m", 32'(A3_M), 32'd3);
    chk("stl_tnm", 32'(Tnew_M), 32'd1);
    chk("stl_cnt", 32'(stall_cnt), 32'd1);
    stop = 1'b0;
    step();
    chk("rel_a3e", 32'(A3_E), 32'd3);
    chk("rel_a3m", 32'(A3_M), 32'd0);
    chk("rel_a3w", 32'(A3_W), 32'd3);
    chk("rel_cnt", 32'(stall_cnt), 32'd1);

    // jal writes $31 with Tnew 0
    instr_D = 32'h0C000010;
    step();
    chk("jal_a3e", 32'(A3_E), 32'd31);
    chk("jal_rwe", 32'(RegWr_E), 32'd1);
    chk("jal_tne", 32'(Tnew_E), 32'd0);
    instr_D = 32'h0;
    step();
    chk("jal_a3m", 32'(A3_M), 32'd31);
    chk("jal_tnm", 32'(Tnew_M), 32'd0);
    step();
    chk("jal_a3w", 32'(A3_W), 32'd31);
    chk("jal_tnw", 32'(Tnew_W), 32'd0);

    // writes to $0 and non-writers
    instr_D = 32'h34000005;
    step();
    chk("ori0_rwe", 32'(RegWr_E), 32'd0);
    chk("ori0_a3e", 32'(A3_E), 32'd0);
    chk("ori0_tne", 32'(Tnew_E), 32'd0);
    instr_D = 32'hAC030000;
    step();
    chk("sw_rwe", 32'(RegWr_E), 32'd0);
    chk("sw_a3e", 32'(A3_E), 32'd0);

    // ori $5 and lui $6 decode rt with Tnew 1
    instr_D = 32'h34050007;
    step();
    chk("ori_a3e", 32'(A3_E), 32'd5);
    chk("ori_tne", 32'(Tnew_E), 32'd1);
    instr_D = 32'h3C061234;
    step();
    chk("lui_a3e", 32'(A3_E), 32'd6);
    chk("lui_rwe", 32'(RegWr_E), 32'd1);

    // back-to-back addu $1, subu $2, lw $4
    instr_D = 32'h00000821;
    step();
    instr_D = 32'h00001023;
    step();
    instr_D = 32'h8C040000;
    step();
    chk("b2b_a3e", 32'(A3_E), 32'd4);
    chk("b2b_a3m", 32'(A3_M), 32'd2);
    chk("b2b_a3w", 32'(A3_W), 32'd1);
    chk("b2b_tne", 32'(Tnew_E), 32'd2);
    chk("b2b_tnm", 32'(Tnew_M), 32'd0);
    chk("b2b_tnw", 32'(Tnew_W), 32'd0);
    chk("b2b_rww", 32'(RegWr_W), 32'd1);

    // asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    chk("ars_a3e", 32'(A3_E), 32'd0);
    chk("ars_a3m", 32'(A3_M), 32'd0);
    chk("ars_a3w", 32'(A3_W), 32'd0);
    chk("ars_rww", 32'(RegWr_W), 32'd0);
    chk("ars_tne", 32'(Tnew_E), 32'd0);
    chk("ars_cnt", 32'(stall_cnt), 32'd0);
    #2;
    reset = 1'b1;
    instr_D = 32'h8C030000;
    step();
    chk("post_a3e", 32'(A3_E), 32'd3);
    chk("post_tne", 32'(Tnew_E), 32'd2);

    // stall counter saturation
    stop = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 5; i++) step();
    chk("sat_15", 32'(stall_cnt), 32'd15);
    chk("sat_a3e", 32'(A3_E), 32'd0);
    stop = 1'b0;
    step();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    chk("sat_rel", 32'(A3_E), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
Producer side of the D-stage stall check. Decodes the instruction in D, then carries each instruction's write-back info (destination A3, RegWr, Tnew) down the E/M/W pipeline registers. Tnew counts down by one per stage. When the stall check raises stop, a bubble is injected into E. Outputs feed the stall unit (A3_E/M, RegWr_E/M, Tnew_E/M/W) and the forwarding muxes (A3_W, RegWr_W).

Parameters:
RA_REG, 31, destination register number used by jal
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_D  input  32  instruction currently in D
stop  input  1  stall request from the stall unit; 1 = freeze D, bubble into E
A3_E  output  5  destination register of the instruction in E
A3_M  output  5  destination register of the instruction in M
A3_W  output  5  destination register of the instruction in W
RegWr_E  output  1  the instruction in E writes the GPR file
RegWr_M  output  1  the instruction in M writes the GPR file
RegWr_W  output  1  the instruction in W writes the GPR file
Tnew_E  output  2  cycles until the result of the instruction in E is available
Tnew_M  output  2  Tnew of the instruction in M
Tnew_W  output  2  Tnew of the instruction in W
stall_cnt  output  CNT_W  total cycles with stop=1 since reset, saturating

Behaviour:
- Decode (combinational on instr_D; op = [31:26], func = [5:0]) gives A3d, RWd and Tnd.
  - addu: op=0, func=0x21. A3 = rd [15:11], RegWr = 1, Tnew = 1.
  - subu: op=0, func=0x23. A3 = rd, RegWr = 1, Tnew = 1.
  - ori: op=0x0d. A3 = rt [20:16], RegWr = 1, Tnew = 1.
  - lui: op=0x0f. A3 = rt, RegWr = 1, Tnew = 1.
  - lw: op=0x23. A3 = rt, RegWr = 1, Tnew = 2.
  - jal: op=0x03. A3 = RA_REG, RegWr = 1, Tnew = 0.
  - sw, beq, j, jr, and every other encoding (including 0x00000000): A3 = 0, RegWr = 0, Tnew = 0.
- Whenever the computed A3 is 0, force RegWr = 0 and Tnew = 0, so writes to $0 never register as hazards.
- E register, on each rising clk edge:
  - stop = 0: load {A3d, RWd, Tnd}.
  - stop = 1: load a bubble {0, 0, 0}.
- M register: loads the E contents each edge; Tnew_M = (Tnew_E == 0) ? 0 : Tnew_E - 1.
- W register: loads the M contents each edge, with the same saturating decrement.
- The M and W registers advance unconditionally; stop never freezes them.
- stall_cnt: increments by 1 on each edge where stop = 1. It saturates at all-ones and never wraps.
- Reset (reset = 0, asynchronous, may assert mid-stream): all A3, RegWr, Tnew outputs go to 0 and stall_cnt goes to 0 immediately. The first edge after reset deasserts samples instr_D normally.
- Latency:
  - The decoded D info appears on the E outputs 1 cycle later.
  - It appears on the M outputs 2 cycles later and on the W outputs 3 cycles later.
- Every value ever seen on Tnew_M or Tnew_W is within 0..1; Tnew_W is always 0.
- No combinational path from stop or instr_D to any output; all outputs are registered.

Test Plan:
- Reset, then instr_D = 0x8C030000 (lw $3,0($0)) for one edge -> A3_E = 3, RegWr_E = 1, Tnew_E = 2; next edge A3_M = 3, Tnew_M = 1; next edge A3_W = 3, Tnew_W = 0.
- lw $3 in D with stop = 1 for one cycle -> E holds a bubble (A3_E = 0, RegWr_E = 0, Tnew_E = 0) while M advances; stall_cnt = 1. Then stop = 0 -> A3_E = 3 again.
- jal (0x0C000010) -> A3_E = 31, RegWr_E = 1, Tnew_E = 0; on the following edges Tnew_M = 0 and Tnew_W = 0.
- ori $0,$0,5 (0x34000005) and sw (0xAC030000) -> RegWr_E = 0, A3_E = 0.
- Back-to-back addu $1 / subu $2 / lw $4 with no stall -> A3_E/M/W = 4/2/1 after the third edge; Tnew_E/M/W = 2/0/0.
- Assert reset mid-stream with all stages valid -> all outputs 0 before the next clk edge; stall_cnt = 0. Hold stop = 1 for 2^CNT_W + 3 cycles (CNT_W = 4 build) -> stall_cnt stays at 15.
